// File: rtl/arm_cortex_m0_pkg.sv
// Shared decode/execute definitions for the Thumb-16 subset.
// Opcode encodings here are also consumed by the execute stage.
package arm_cortex_m0_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 8;
    localparam int REG_IDX_W  = 3;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b1010;
    localparam logic [3:0] OP_LSR = 4'b1011;

    localparam logic [4:0] PAT_LSL   = 5'b00000;
    localparam logic [4:0] PAT_LSR   = 5'b00001;
    localparam logic [4:0] PAT_MOVS  = 5'b00100;
    localparam logic [6:0] PAT_ADD_R = 7'b0001100;
    localparam logic [6:0] PAT_SUB_R = 7'b0001101;
    localparam logic [6:0] PAT_ADD_I = 7'b0001110;
    localparam logic [6:0] PAT_SUB_I = 7'b0001111;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] op;
        logic [4:0] shamt;
        reg_idx_t   rd;
        reg_idx_t   ra;
        reg_idx_t   rb;
        logic       use_a;
        logic       use_b;
        logic [7:0] imm;
    } dec_t;

    // Operands not read from the register file take imm (zero-extended).
    function automatic dec_t thumb_decode(input logic [15:0] ins);
        dec_t d;
        d = '0;
        unique case (1'b1)
            ins[15:11] == PAT_LSL,
            ins[15:11] == PAT_LSR: begin
                d.legal = 1'b1;
                d.op    = ins[11] ? OP_LSR : OP_LSL;
                d.shamt = ins[10:6];
                d.rb    = ins[5:3];
                d.use_b = 1'b1;
                d.rd    = ins[2:0];
            end
            ins[15:9] == PAT_ADD_R,
            ins[15:9] == PAT_SUB_R: begin
                d.legal = 1'b1;
                d.op    = ins[9] ? OP_SUB : OP_ADD;
                d.rb    = ins[8:6];
                d.ra    = ins[5:3];
                d.use_a = 1'b1;
                d.use_b = 1'b1;
                d.rd    = ins[2:0];
            end
            ins[15:9] == PAT_ADD_I,
            ins[15:9] == PAT_SUB_I: begin
                d.legal = 1'b1;
                d.op    = ins[9] ? OP_SUB : OP_ADD;
                d.imm   = {5'b0, ins[8:6]};
                d.ra    = ins[5:3];
                d.use_a = 1'b1;
                d.rd    = ins[2:0];
            end
            ins[15:11] == PAT_MOVS: begin
                d.legal = 1'b1;
                d.op    = OP_ADD;
                d.rd    = ins[10:8];
                d.imm   = ins[7:0];
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_cortex_m0_decode_if.sv
// Fetch, execute and writeback signals around the decode stage.
// slave = decode stage, master = the surrounding pipeline.
interface arm_cortex_m0_decode_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  instr_valid;
    logic [15:0]           instr;
    logic                  instr_ready;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [3:0]            opcode;
    logic [4:0]            shift_amount;
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;
    logic [2:0]            dest_reg;
    logic                  illegal;
    logic                  wb_en;
    logic [2:0]            wb_reg;
    logic [DATA_WIDTH-1:0] wb_data;

    modport slave (
        input  instr_valid, instr, ex_ready,
        input  wb_en, wb_reg, wb_data,
        output instr_ready, ex_valid, opcode, shift_amount,
        output operand_A, operand_B, dest_reg, illegal
    );

    modport master (
        output instr_valid, instr, ex_ready,
        output wb_en, wb_reg, wb_data,
        input  instr_ready, ex_valid, opcode, shift_amount,
        input  operand_A, operand_B, dest_reg, illegal
    );
endinterface

// File: rtl/arm_cortex_m0_regfile.sv
// R0-R7 register file: two combinational read ports with
// same-cycle writeback bypass, one synchronous write port.
module arm_cortex_m0_regfile
    import arm_cortex_m0_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NREGS = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  reg_idx_t      i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  reg_idx_t      i_raddr_a,
    input  reg_idx_t      i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_regs [NREGS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_we && i_waddr == i_raddr_a) ?
                       i_wdata : r_regs[i_raddr_a];
    assign o_rdata_b = (i_we && i_waddr == i_raddr_b) ?
                       i_wdata : r_regs[i_raddr_b];

endmodule

// File: rtl/arm_cortex_m0_decode.sv
// Thumb-16 decode stage: operand read, RAW scoreboard interlock
// and a one-deep output register towards execute.
module arm_cortex_m0_decode
    import arm_cortex_m0_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NREGS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    arm_cortex_m0_decode_if.slave bus
);

    dec_t          w_dec;
    logic [DW-1:0] w_rf_a;
    logic [DW-1:0] w_rf_b;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic          w_clr_a;
    logic          w_clr_b;
    logic          w_hazard;
    logic          w_ready;
    logic          w_accept;

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    logic          r_ex_valid;
    logic [3:0]    r_opcode;
    logic [4:0]    r_shamt;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    reg_idx_t      r_dest;
    logic          r_illegal;

    assign w_dec = thumb_decode(bus.instr);

    arm_cortex_m0_regfile #(
        .DW    (DW),
        .NREGS (NREGS)
    ) u_regfile (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (bus.wb_en),
        .i_waddr   (bus.wb_reg),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_dec.ra),
        .i_raddr_b (w_dec.rb),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

    assign w_op_a = w_dec.use_a ? w_rf_a : '0;
    assign w_op_b = w_dec.use_b ? w_rf_b :
                    {{(DW-8){1'b0}}, w_dec.imm};

    // A pending source being retired this cycle is served by bypass.
    assign w_clr_a  = bus.wb_en && (bus.wb_reg == w_dec.ra);
    assign w_clr_b  = bus.wb_en && (bus.wb_reg == w_dec.rb);
    assign w_hazard = (w_dec.use_a && r_pend[w_dec.ra] && !w_clr_a)
                   || (w_dec.use_b && r_pend[w_dec.rb] && !w_clr_b);

    assign w_ready  = (!r_ex_valid || bus.ex_ready) && !w_hazard;
    assign w_accept = bus.instr_valid && w_ready;

    // Set after clear so a new writer stays outstanding.
    always_comb begin
        w_pend_nxt = r_pend;
        if (bus.wb_en) begin
            w_pend_nxt[bus.wb_reg] = 1'b0;
        end
        if (w_accept && w_dec.legal) begin
            w_pend_nxt[w_dec.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_opcode   <= OP_NOP;
            r_shamt    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_dest     <= '0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_opcode   <= w_dec.op;
            r_shamt    <= w_dec.shamt;
            r_op_a     <= w_op_a;
            r_op_b     <= w_op_b;
            r_dest     <= w_dec.rd;
            r_illegal  <= !w_dec.legal;
        end else if (bus.ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign bus.instr_ready  = w_ready;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.opcode       = r_opcode;
    assign bus.shift_amount = r_shamt;
    assign bus.operand_A    = r_op_a;
    assign bus.operand_B    = r_op_b;
    assign bus.dest_reg     = r_dest;
    assign bus.illegal      = r_illegal;

endmodule

// File: tb/tb_arm_cortex_m0_decode.sv
// Directed bench for the Thumb-16 decode stage.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_arm_cortex_m0_decode;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    arm_cortex_m0_decode_if #(.DATA_WIDTH(32)) bus ();

    arm_cortex_m0_decode #(
        .DW    (32),
        .NREGS (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag,
                           input logic        v,
                           input logic [3:0]  op,
                           input logic [4:0]  sh,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [2:0]  d,
                           input logic        ill);
        chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(v));
        chk({tag, ".op"}, 32'(bus.opcode), 32'(op));
        chk({tag, ".shift"}, 32'(bus.shift_amount), 32'(sh));
        chk({tag, ".A"}, bus.operand_A, a);
        chk({tag, ".B"}, bus.operand_B, b);
        chk({tag, ".dest"}, 32'(bus.dest_reg), 32'(d));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    endtask

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.ex_ready    = 1'b1;
        bus.wb_en       = 1'b0;
        bus.wb_reg      = 3'd0;
        bus.wb_data     = 32'd0;
        tick;
        tick;
        rst = 1'b0;
        chk_out("reset", 0, 4'h0, 0, 0, 0, 0, 0);
        #1 chk("reset.ready", 32'(bus.instr_ready), 1);

        // MOVS R1,#10 then MOVS R2,#5 back to back
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h210A;
        #1 chk("movs1.ready", 32'(bus.instr_ready), 1);
        tick;
        chk_out("movs1", 1, 4'b0100, 0, 0, 10, 1, 0);
        bus.instr = 16'h2205;
        tick;
        chk_out("movs2", 1, 4'b0100, 0, 0, 5, 2, 0);

        // ADDS R3,R1,R2 interlocked on R1 and R2
        bus.instr = 16'h188B;
        #1 chk("add.haz0", 32'(bus.instr_ready), 0);
        tick;
        chk("add.drain", 32'(bus.ex_valid), 0);
        bus.wb_en   = 1'b1;
        bus.wb_reg  = 3'd1;
        bus.wb_data = 32'd10;
        #1 chk("add.haz1", 32'(bus.instr_ready), 0);
        tick;
        chk("add.still", 32'(bus.ex_valid), 0);
        bus.wb_reg  = 3'd2;
        bus.wb_data = 32'd5;
        #1 chk("add.bypass_ready", 32'(bus.instr_ready), 1);
        tick;
        chk_out("add", 1, 4'b0100, 0, 10, 5, 3, 0);

        // R2=15 (not pending), retire R3
        bus.instr_valid = 1'b0;
        bus.wb_reg      = 3'd2;
        bus.wb_data     = 32'd15;
        tick;
        chk("idle.drain", 32'(bus.ex_valid), 0);
        bus.wb_reg  = 3'd3;
        bus.wb_data = 32'd15;
        tick;
        bus.wb_en = 1'b0;

        // SUBS R0,R1,R2
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h1A88;
        tick;
        chk_out("sub", 1, 4'b0010, 0, 10, 15, 0, 0);

        // LSLS R4,R2,#8 then LSRS R4,R2,#2
        bus.instr = 16'h0214;
        #1 chk("lsl.ready", 32'(bus.instr_ready), 1);
        tick;
        chk_out("lsl", 1, 4'b1010, 8, 0, 15, 4, 0);
        bus.instr = 16'h0894;
        tick;
        chk_out("lsr", 1, 4'b1011, 2, 0, 15, 4, 0);

        // Stall three cycles with ADDS R5,R1,#3 waiting
        bus.ex_ready = 1'b0;
        bus.instr    = 16'h1CCD;
        #1 chk("stall.ready", 32'(bus.instr_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out("stall", 1, 4'b1011, 2, 0, 15, 4, 0);
            chk("stall.ready_n", 32'(bus.instr_ready), 0);
        end
        bus.ex_ready = 1'b1;
        #1 chk("release.ready", 32'(bus.instr_ready), 1);
        tick;
        chk_out("addi", 1, 4'b0100, 0, 10, 3, 5, 0);

        // Illegal 0xBF00 while R0 retires
        bus.instr   = 16'hBF00;
        bus.wb_en   = 1'b1;
        bus.wb_reg  = 3'd0;
        bus.wb_data = 32'd7;
        tick;
        chk_out("illegal", 1, 4'b0000, 0, 0, 0, 0, 1);

        // ADDS R6,R0,#1: R0 must not be pending after the illegal op
        bus.instr   = 16'h1C46;
        bus.wb_reg  = 3'd6;
        bus.wb_data = 32'd9;
        #1 chk("ill.nosb", 32'(bus.instr_ready), 1);
        tick;
        chk_out("addr0", 1, 4'b0100, 0, 7, 1, 6, 0);
        bus.wb_en = 1'b0;

        // ADDS R7,R6,#0: R6 still pending (set beat clear)
        bus.instr    = 16'h1C37;
        bus.ex_ready = 1'b0;
        #1 chk("setwins", 32'(bus.instr_ready), 0);
        tick;
        chk("stall2.valid", 32'(bus.ex_valid), 1);

        // Reset while stalled, with a competing writeback to R1
        rst         = 1'b1;
        bus.wb_en   = 1'b1;
        bus.wb_reg  = 3'd1;
        bus.wb_data = 32'h55;
        tick;
        rst       = 1'b0;
        bus.wb_en = 1'b0;
        chk_out("rst2", 0, 4'h0, 0, 0, 0, 0, 0);
        bus.ex_ready = 1'b1;
        #1 chk("rst2.sbclear", 32'(bus.instr_ready), 1);
        tick;
        chk_out("r6zero", 1, 4'b0100, 0, 0, 0, 7, 0);
        bus.instr = 16'h1A88;
        tick;
        chk_out("r1zero", 1, 4'b0010, 0, 0, 0, 0, 0);
        bus.instr_valid = 1'b0;
        tick;
        chk("final.drain", 32'(bus.ex_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
